// File: rtl/pixel_frame_uart_pkg.sv
// Shared constants, FSM encoding and frame-length helper for the pixel frame UART.
`timescale 1ns/1ps
package pixel_frame_uart_pkg;

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam int         UART_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    // Header, two bytes per pixel, trailing checksum.
    function automatic int byte_count(input int rows, input int cols);
        return 2 * rows * cols + 2;
    endfunction

endpackage

// File: rtl/pixel_frame_uart_if.sv
// Sample/scan inputs from the readout sequencer and the host-facing UART/status outputs.
`timescale 1ns/1ps
interface pixel_frame_uart_if #(
    parameter int DataW = 12,
    parameter int Rows  = 4,
    parameter int Cols  = 4
);
    logic                      valid_i;
    logic [DataW-1:0]          data_i;
    logic [$clog2(Rows)-1:0]   row_i;
    logic [$clog2(Cols)-1:0]   col_i;
    logic                      eos_i;
    logic                      tx_o;
    logic                      busy_o;
    logic                      overrun_o;
    logic [7:0]                frame_cnt_o;

    modport master (
        output valid_i, data_i, row_i, col_i, eos_i,
        input  tx_o, busy_o, overrun_o, frame_cnt_o
    );

    modport slave (
        input  valid_i, data_i, row_i, col_i, eos_i,
        output tx_o, busy_o, overrun_o, frame_cnt_o
    );
endinterface

// File: rtl/pixel_frame_uart_uart_tx_byte.sv
// 8N1 UART transmitter for a single byte; done_o marks the last cycle of the stop bit.
`timescale 1ns/1ps
module uart_tx_byte
    import pixel_frame_uart_pkg::*;
#(
    parameter int BaudDiv = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       busy_o
);
    localparam int              BW        = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BaudDiv - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(UART_BITS - 1);

    logic          busy_reg;
    logic          tx_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [8:0]    shift_reg;
    logic          bit_end;

    assign bit_end = busy_reg && (baud_cnt_reg == BAUD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_reg     <= 1'b0;
            tx_reg       <= 1'b1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else if (!busy_reg) begin
            if (start_i) begin
                busy_reg     <= 1'b1;
                tx_reg       <= 1'b0;
                shift_reg    <= {1'b1, data_i};
                baud_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end
        end else if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
                busy_reg <= 1'b0;
                tx_reg   <= 1'b1;
            end else begin
                // Shift register holds data LSB-first followed by the stop bit.
                tx_reg      <= shift_reg[0];
                shift_reg   <= {1'b0, shift_reg[8:1]};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
        end else begin
            baud_cnt_reg <= baud_cnt_reg + BW'(1);
        end
    end

    assign tx_o   = tx_reg;
    assign busy_o = busy_reg;
    assign done_o = bit_end && (bit_cnt_reg == BIT_LAST);

endmodule

// File: rtl/pixel_frame_uart.sv
// Captures ADC samples into a Rows x Cols buffer and ships the frame over UART on end-of-scan.
`timescale 1ns/1ps
module pixel_frame_uart
    import pixel_frame_uart_pkg::*;
#(
    parameter int         Rows    = 4,
    parameter int         Cols    = 4,
    parameter int         DataW   = 12,
    parameter int         BaudDiv = 868,
    parameter logic [7:0] Header  = HEADER
) (
    input logic               clk_i,
    input logic               rst_i,
    pixel_frame_uart_if.slave bus
);
    localparam int             NPIX     = Rows * Cols;
    localparam int             NBYTES   = byte_count(Rows, Cols);
    localparam int             IW       = $clog2(NBYTES);
    localparam int             AW       = $clog2(NPIX);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NBYTES - 1);

    state_t           state_reg, state_next;
    logic [IW-1:0]    byte_idx_reg;
    logic [7:0]       chk_reg;
    logic [7:0]       frame_cnt_reg;
    logic             overrun_reg;
    logic [DataW-1:0] pix_reg [NPIX];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    pix_sel;
    logic [15:0]      pix_wide;
    logic [7:0]       tx_byte;
    logic             uart_start, uart_done, uart_busy, uart_tx;

    // Row-major address; power-of-two dimensions make it a plain concatenation.
    assign wr_en   = bus.valid_i && (state_reg == ST_IDLE);
    assign wr_addr = {bus.row_i, bus.col_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NPIX; i++) pix_reg[i] <= '0;
        end else if (wr_en) begin
            pix_reg[wr_addr] <= bus.data_i;
        end
    end

    // Byte index 1,3,5.. carries the high byte of pixel (idx-1)/2, even indices the low byte.
    assign pix_sel  = AW'((byte_idx_reg - IW'(1)) >> 1);
    assign pix_wide = 16'(pix_reg[pix_sel]);

    always_comb begin
        tx_byte = byte_idx_reg[0] ? pix_wide[15:8] : pix_wide[7:0];
        if (byte_idx_reg == '0)
            tx_byte = Header;
        else if (byte_idx_reg == LAST_IDX)
            tx_byte = chk_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        uart_start = 1'b0;
        case (state_reg)
            ST_IDLE: if (bus.eos_i) state_next = ST_LOAD;
            ST_LOAD: begin
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (uart_done)
                    state_next = (byte_idx_reg == LAST_IDX) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_idx_reg  <= '0;
            chk_reg       <= '0;
            frame_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && bus.eos_i) begin
                byte_idx_reg <= '0;
                chk_reg      <= '0;
            end
            // Checksum accumulates pixel bytes as they go out, so it is ready at the last index.
            if (state_reg == ST_LOAD && byte_idx_reg != '0 && byte_idx_reg != LAST_IDX)
                chk_reg <= chk_reg ^ tx_byte;
            if (state_reg == ST_SEND && uart_done && byte_idx_reg != LAST_IDX)
                byte_idx_reg <= byte_idx_reg + IW'(1);
            if (state_reg == ST_DONE)
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            if (state_reg != ST_IDLE && (bus.valid_i || bus.eos_i))
                overrun_reg <= 1'b1;
        end
    end

    uart_tx_byte #(
        .BaudDiv (BaudDiv)
    ) u_uart (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (uart_start),
        .data_i  (tx_byte),
        .tx_o    (uart_tx),
        .done_o  (uart_done),
        .busy_o  (uart_busy)
    );

    assign bus.tx_o        = uart_tx;
    assign bus.busy_o      = (state_reg != ST_IDLE);
    assign bus.overrun_o   = overrun_reg;
    assign bus.frame_cnt_o = frame_cnt_reg;

endmodule

// File: tb/tb_pixel_frame_uart.sv
// Scoreboard bench: frames are predicted from a pixel model and checked byte by byte at the UART pin.
`timescale 1ns/1ps
module tb_pixel_frame_uart;
    localparam int BAUD     = 4;
    localparam int NPIX     = 16;
    localparam int NBYTES   = 2 * NPIX + 2;
    localparam int BUSY_CYC = NBYTES * (10 * BAUD + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_frame_uart_if #(.DataW(12), .Rows(4), .Cols(4)) bus ();

    pixel_frame_uart #(
        .Rows(4), .Cols(4), .DataW(12), .BaudDiv(BAUD), .Header(8'hA5)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         rx_cnt  = 0;
    int         exp_frames = 0;
    logic [11:0] model [NPIX];
    logic [7:0]  exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic push_frame();
        logic [7:0] chk, hi, lo;
        chk = 8'h00;
        exp_q.push_back(8'hA5);
        for (int p = 0; p < NPIX; p++) begin
            hi = {4'h0, model[p][11:8]};
            lo = model[p][7:0];
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            chk = chk ^ hi ^ lo;
        end
        exp_q.push_back(chk);
    endtask

    task automatic write_pix(input int r, input int c, input logic [11:0] d);
        @(posedge clk); #1;
        bus.valid_i = 1'b1;
        bus.row_i   = 2'(r);
        bus.col_i   = 2'(c);
        bus.data_i  = d;
        model[r * 4 + c] = d;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    // Pulses eos (optionally with a same-cycle write), then follows busy_o to the end of the frame.
    task automatic run_frame(input bit sim_wr, input int r, input int c,
                             input logic [11:0] d, input bit inj);
        int cnt;
        cnt    = 0;
        rx_cnt = 0;
        @(posedge clk); #1;
        if (sim_wr) begin
            bus.valid_i = 1'b1;
            bus.row_i   = 2'(r);
            bus.col_i   = 2'(c);
            bus.data_i  = d;
            model[r * 4 + c] = d;
        end
        bus.eos_i = 1'b1;
        push_frame();
        @(posedge clk); #1;
        bus.eos_i   = 1'b0;
        bus.valid_i = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b1) break;
            if (cnt == 0) check("tx_idle_in_load", bus.tx_o, 1);
            if (cnt == 1) check("start_edge", bus.tx_o, 0);
            if (inj && cnt == 200) begin
                bus.valid_i = 1'b1;
                bus.eos_i   = 1'b1;
                bus.row_i   = 2'd0;
                bus.col_i   = 2'd1;
                bus.data_i  = 12'h111;
            end
            if (inj && cnt == 201) begin
                bus.valid_i = 1'b0;
                bus.eos_i   = 1'b0;
            end
            if (inj && cnt == 203) check("overrun_set", bus.overrun_o, 1);
            cnt++;
        end
        check("busy_len", cnt, BUSY_CYC);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("frame_drained", exp_q.size(), 0);
        check("bytes_received", rx_cnt, NBYTES);
        exp_frames++;
        check("frame_cnt", bus.frame_cnt_o, 32'(exp_frames & 255));
    endtask

    // UART receiver: samples mid-bit at negedges; bytes disturbed by reset are discarded.
    initial begin : uart_monitor
        forever begin
            logic [7:0] b;
            logic [7:0] e;
            logic       stop_b;
            bit         ab;
            @(negedge clk);
            if (rst === 1'b0 && bus.tx_o === 1'b0) begin
                ab = 0;
                repeat (2) begin @(negedge clk); if (rst) ab = 1; end
                for (int k = 0; k < 8; k++) begin
                    repeat (BAUD) begin @(negedge clk); if (rst) ab = 1; end
                    b[k] = bus.tx_o;
                end
                repeat (BAUD) begin @(negedge clk); if (rst) ab = 1; end
                stop_b = bus.tx_o;
                if (!ab) begin
                    check("stop_bit", 32'(stop_b), 1);
                    check("byte_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("byte%0d", rx_cnt), 32'(b), 32'(e));
                        $display("rx byte %0d: %02h (expected %02h)", rx_cnt, b, e);
                        rx_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.eos_i   = 1'b0;
        bus.data_i  = '0;
        bus.row_i   = '0;
        bus.col_i   = '0;
        for (int p = 0; p < NPIX; p++) model[p] = 12'h000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_tx", bus.tx_o, 1);
        check("reset_busy", bus.busy_o, 0);
        check("reset_overrun", bus.overrun_o, 0);
        check("reset_frame_cnt", bus.frame_cnt_o, 0);

        // All-zero frame straight out of reset.
        run_frame(0, 0, 0, 12'h000, 0);

        // Two corner pixels.
        write_pix(0, 0, 12'hABC);
        write_pix(3, 3, 12'h123);
        run_frame(0, 0, 0, 12'h000, 0);

        // Overwrite of the same address.
        write_pix(1, 2, 12'hFFF);
        write_pix(1, 2, 12'h555);
        run_frame(0, 0, 0, 12'h000, 0);

        // Write and eos in the same cycle.
        run_frame(1, 2, 1, 12'h777, 0);

        // Traffic during transmission must not alter the stream.
        check("overrun_pre", bus.overrun_o, 0);
        run_frame(0, 0, 0, 12'h000, 1);
        check("overrun_sticky", bus.overrun_o, 1);
        repeat (20) @(negedge clk);
        check("overrun_still", bus.overrun_o, 1);
        check("frame_cnt_hold", bus.frame_cnt_o, 32'(exp_frames));

        // Reset in the middle of byte 5.
        rx_cnt = 0;
        @(posedge clk); #1;
        bus.eos_i = 1'b1;
        push_frame();
        @(posedge clk); #1;
        bus.eos_i = 1'b0;
        for (int i = 0; i < 3000 && rx_cnt < 5; i++) @(negedge clk);
        for (int i = 0; i < 100 && bus.tx_o !== 1'b0; i++) @(negedge clk);
        check("reached_byte5", rx_cnt, 5);
        check("byte5_start", bus.tx_o, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_tx_async", bus.tx_o, 1);
        check("rst_busy", bus.busy_o, 0);
        check("rst_frame_cnt", bus.frame_cnt_o, 0);
        check("rst_overrun", bus.overrun_o, 0);
        exp_q.delete();
        exp_frames = 0;
        for (int p = 0; p < NPIX; p++) model[p] = 12'h000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        write_pix(0, 1, 12'h3C5);
        run_frame(0, 0, 0, 12'h000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
